fpu_result_fifo: RTL and testbench

//  Consumer end of the fpu_add_pipelined result interface: captures every FP16 result/valid_out pulse

---
 rtl/fpu_pkg.sv | 24 ++
 rtl/fp16_classify.sv | 35 +++
 rtl/fpu_result_fifo.sv | 162 ++++++++++++++++
 tb/tb_fpu_result_fifo.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared FP16 field positions, classification constants and
//                sticky-flag bit indices for the FPU result path.
//  Revision    : 1.0  initial release
// ============================================================================
package fpu_pkg;

    // FP16 layout: [15] sign, [14:10] exponent, [9:0] mantissa
    localparam int         EXP_MSB      = 14;
    localparam int         EXP_LSB      = 10;
    localparam int         MAN_MSB      = 9;
    localparam logic [4:0] EXP_ALL_ONES = 5'h1F;

    // Bit positions inside the {saw_nan, saw_inf, saw_zero} flag vector
    localparam int FLAG_NAN  = 2;
    localparam int FLAG_INF  = 1;
    localparam int FLAG_ZERO = 0;

    typedef logic [2:0] fp_flags_t;

endpackage
`default_nettype wire

// File: rtl/fp16_classify.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_classify
//  Description : Purely combinational FP16 classifier. Takes the magnitude
//                bits of a half-precision word (sign excluded, since none of
//                the classes depend on it) and reports NaN / Inf / zero.
//  Ports       : mag      in  15  FP16 word bits [14:0]
//                is_nan   out 1   exponent all ones, mantissa non-zero
//                is_inf   out 1   exponent all ones, mantissa zero
//                is_zero  out 1   +0 or -0
//  Revision    : 1.0  initial release
// ============================================================================
module fp16_classify
    import fpu_pkg::*;
(
    input  logic [EXP_MSB:0] mag,
    output logic             is_nan,
    output logic             is_inf,
    output logic             is_zero
);

    logic [EXP_MSB-EXP_LSB:0] w_exp;
    logic [MAN_MSB:0]         w_man;
    logic                     w_exp_max;

    assign w_exp     = mag[EXP_MSB:EXP_LSB];
    assign w_man     = mag[MAN_MSB:0];
    assign w_exp_max = (w_exp == EXP_ALL_ONES);

    assign is_nan  = w_exp_max && (w_man != '0);
    assign is_inf  = w_exp_max && (w_man == '0);
    assign is_zero = (mag == '0);

endmodule
`default_nettype wire

// File: rtl/fpu_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_result_fifo
//  Description : Show-ahead FIFO capturing FP16 results from the pipelined
//                adder (which cannot be stalled) and serving them to the bus
//                read side. Dropped results set a sticky overflow bit.
//  Build macro : FPU_RES_FLAGS_EN - when defined, every accepted result is
//                classified and sticky {saw_nan, saw_inf, saw_zero} flags are
//                kept; otherwise flags reads as 3'b000.
//  Ports       : clk        in  1        rising-edge clock
//                rst_n      in  1        asynchronous active-low reset
//                res_in     in  WIDTH    result word from the adder
//                res_valid  in  1        push strobe (single-cycle pulses)
//                rd_en      in  1        pop strobe
//                clr        in  1        synchronous flush, beats push/pop
//                rd_data    out WIDTH    head entry, 0 while empty
//                rd_valid   out 1        FIFO non-empty
//                full       out 1        count == DEPTH
//                count      out CNT_W    occupancy 0..DEPTH
//                overflow   out 1        sticky: a result was dropped
//                flags      out 3        sticky result classes
//  Revision    : 1.0  initial release
// ============================================================================
module fpu_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         res_in,
    input  logic                     res_valid,
    input  logic                     rd_en,
    input  logic                     clr,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [2:0]               flags
);
    import fpu_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             overflow_q, overflow_d;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_wr_en;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == CNT_W'(DEPTH));

    // A pop on an empty FIFO is ignored. A push while full is still
    // accepted if a genuine pop frees the head slot in the same cycle.
    assign w_pop   = rd_en && !w_empty;
    assign w_push  = res_valid && (!w_full || w_pop);
    assign w_wr_en = w_push && !clr;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (res_valid && !w_push) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= res_in;
        end
    end

    assign rd_data  = w_empty ? '0 : mem_q[rd_ptr_q];
    assign rd_valid = !w_empty;
    assign full     = w_full;
    assign count    = count_q;
    assign overflow = overflow_q;

`ifdef FPU_RES_FLAGS_EN
    logic      w_is_nan;
    logic      w_is_inf;
    logic      w_is_zero;
    fp_flags_t flags_q, flags_d;

    fp16_classify u_classify (
        .mag     (res_in[EXP_MSB:0]),
        .is_nan  (w_is_nan),
        .is_inf  (w_is_inf),
        .is_zero (w_is_zero)
    );

    // Only results that actually enter the FIFO are classified.
    always_comb begin
        flags_d = flags_q;
        if (clr) begin
            flags_d = '0;
        end else if (w_push) begin
            flags_d[FLAG_NAN]  = flags_q[FLAG_NAN]  | w_is_nan;
            flags_d[FLAG_INF]  = flags_q[FLAG_INF]  | w_is_inf;
            flags_d[FLAG_ZERO] = flags_q[FLAG_ZERO] | w_is_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`else
    assign flags = 3'b000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_result_fifo
//  Description : Self-checking bench for fpu_result_fifo (WIDTH=16, DEPTH=4).
//                Per-cycle vector table plus hand sequences for flags,
//                flush-with-push and asynchronous reset mid-burst.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fpu_result_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] res_in;
    logic             res_valid;
    logic             rd_en;
    logic             clr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic [2:0]       count;
    logic             overflow;
    logic [2:0]       flags;

    int n_total  = 0;
    int n_passed = 0;

    fpu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_in    (res_in),
        .res_valid (res_valid),
        .rd_en     (rd_en),
        .clr       (clr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [15:0] din;
        logic        pop;
        logic        flush;
        logic [15:0] e_data;
        logic        e_valid;
        logic [2:0]  e_count;
        logic        e_full;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic p, input logic [15:0] d, input logic r,
                                input logic c, input logic [15:0] ed, input logic ev,
                                input logic [2:0] ec, input logic ef, input logic eo);
        vec_t v;
        v.push = p; v.din = d; v.pop = r; v.flush = c;
        v.e_data = ed; v.e_valid = ev; v.e_count = ec; v.e_full = ef; v.e_ovf = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_passed++;
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 ns later.
    task automatic step(input logic p, input logic [15:0] d, input logic r, input logic c);
        res_valid = p;
        res_in    = d;
        rd_en     = r;
        clr       = c;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        rd_en     = 1'b0;
        clr       = 1'b0;
    endtask

    logic [2:0] exp_flags;

    initial begin
        rst_n = 1'b0; res_in = '0; res_valid = 1'b0; rd_en = 1'b0; clr = 1'b0;

        // Test 2: ordered read-back
        vecs.push_back(mk(1, 16'h3C00, 0, 0, 16'h3C00, 1, 3'd1, 0, 0));
        vecs.push_back(mk(1, 16'h4000, 0, 0, 16'h3C00, 1, 3'd2, 0, 0));
        vecs.push_back(mk(1, 16'h4200, 0, 0, 16'h3C00, 1, 3'd3, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h4000, 1, 3'd2, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h4200, 1, 3'd1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 3'd0, 0, 0));
        // Test 3: overfill, fifth value dropped
        vecs.push_back(mk(1, 16'h1111, 0, 0, 16'h1111, 1, 3'd1, 0, 0));
        vecs.push_back(mk(1, 16'h2222, 0, 0, 16'h1111, 1, 3'd2, 0, 0));
        vecs.push_back(mk(1, 16'h3333, 0, 0, 16'h1111, 1, 3'd3, 0, 0));
        vecs.push_back(mk(1, 16'h4444, 0, 0, 16'h1111, 1, 3'd4, 1, 0));
        vecs.push_back(mk(1, 16'h5555, 0, 0, 16'h1111, 1, 3'd4, 1, 1));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h2222, 1, 3'd3, 0, 1));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h3333, 1, 3'd2, 0, 1));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h4444, 1, 3'd1, 0, 1));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 3'd0, 0, 1));
        // Flush clears overflow; flush beats a simultaneous push
        vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h0000, 0, 3'd0, 0, 0));
        vecs.push_back(mk(1, 16'h6666, 0, 1, 16'h0000, 0, 3'd0, 0, 0));
        // Test 4: full + push + pop in the same cycle
        vecs.push_back(mk(1, 16'h3C01, 0, 0, 16'h3C01, 1, 3'd1, 0, 0));
        vecs.push_back(mk(1, 16'h3C02, 0, 0, 16'h3C01, 1, 3'd2, 0, 0));
        vecs.push_back(mk(1, 16'h3C03, 0, 0, 16'h3C01, 1, 3'd3, 0, 0));
        vecs.push_back(mk(1, 16'h3C04, 0, 0, 16'h3C01, 1, 3'd4, 1, 0));
        vecs.push_back(mk(1, 16'h4400, 1, 0, 16'h3C02, 1, 3'd4, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h3C03, 1, 3'd3, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h3C04, 1, 3'd2, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h4400, 1, 3'd1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 3'd0, 0, 0));
        // Test 5: pop on empty ignored; pop+push on empty keeps the push
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 3'd0, 0, 0));
        vecs.push_back(mk(1, 16'h3C00, 1, 0, 16'h3C00, 1, 3'd1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 3'd0, 0, 0));

        // Test 1: reset state, during and after reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_rd_data",  32'(rd_data),  32'h0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_flags",    32'(flags),    32'd0);
        rst_n = 1'b1;
        step(0, 16'h0, 0, 0);
        chk("idle_count", 32'(count), 32'd0);
        chk("idle_full",  32'(full),  32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].push, vecs[i].din, vecs[i].pop, vecs[i].flush);
            chk($sformatf("v%0d_rd_data", i),  32'(rd_data),  32'(vecs[i].e_data));
            chk($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_count", i),    32'(count),    32'(vecs[i].e_count));
            chk($sformatf("v%0d_full", i),     32'(full),     32'(vecs[i].e_full));
            chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
        end
        chk("post_table_flags", 32'(flags), 32'd0);

        // Dropped pushes must not classify
        step(0, 16'h0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 16'h3C00, 0, 0);
        step(1, 16'h7C00, 0, 0);
        chk("drop_overflow", 32'(overflow), 32'd1);
        chk("drop_flags",    32'(flags),    32'd0);
        step(0, 16'h0, 0, 1);

        // Test 6: sticky classification flags
`ifdef FPU_RES_FLAGS_EN
        exp_flags = 3'b100;
`else
        exp_flags = 3'b000;
`endif
        step(1, 16'h7E00, 0, 0);
        chk("flag_nan", 32'(flags), 32'(exp_flags));
`ifdef FPU_RES_FLAGS_EN
        exp_flags = 3'b110;
`endif
        step(1, 16'h7C00, 0, 0);
        chk("flag_inf", 32'(flags), 32'(exp_flags));
`ifdef FPU_RES_FLAGS_EN
        exp_flags = 3'b111;
`endif
        step(1, 16'h8000, 0, 0);
        chk("flag_zero", 32'(flags), 32'(exp_flags));
        chk("flag_count", 32'(count), 32'd3);
        step(0, 16'h0, 0, 1);
        chk("clr_flags", 32'(flags), 32'd0);
        chk("clr_count", 32'(count), 32'd0);

        // Asynchronous reset in the middle of a burst
        step(1, 16'h1234, 0, 0);
        step(1, 16'h5678, 0, 0);
        res_valid = 1'b1; res_in = 16'h9ABC;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count",    32'(count),    32'd0);
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        chk("arst_rd_data",  32'(rd_data),  32'h0);
        res_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 16'h0, 0, 0);
        chk("arst_after_count", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
`default_nettype wire
